hub75_bcm_sched: RTL



---
 rtl/hub75_pkg.sv | 31 +++
 rtl/hub75_on_timer.sv | 71 +++++++
 rtl/hub75_bcm_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared types and constants for the HUB75 BCM scan scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    localparam int c_DEF_COL_BITS = 6;
    localparam int c_DEF_ROW_BITS = 5;
    localparam int c_DEF_PLANES   = 8;
    localparam int c_BRIGHT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // Wide enough for (255+1) << (planes-1) plus a few dead cycles.
    function automatic int on_time_width(input int planes);
        return c_BRIGHT_W + planes;
    endfunction

    function automatic int plane_bits(input int planes);
        return (planes > 1) ? $clog2(planes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_on_timer.sv
`default_nettype none
// ============================================================================
// Module      : hub75_on_timer
// Description : Binary-weighted display on-time counter; optional post-latch
//               dead time when HUB75_DEADTIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_on_timer
    import hub75_pkg::*;
#(
    parameter int PLANES = c_DEF_PLANES,
    parameter int PB     = plane_bits(c_DEF_PLANES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PB-1:0]         plane,
    input  logic [c_BRIGHT_W-1:0] brightness,
    output logic                  blank_req,
    output logic                  done
);

    localparam int c_OT_W = on_time_width(PLANES);
`ifdef HUB75_DEADTIME_EN
    localparam int c_DEAD = 2;
`else
    localparam int c_DEAD = 0;
`endif

    logic [c_OT_W-1:0] r_on_cnt;
    logic [c_OT_W-1:0] w_on_time;
    logic [c_OT_W-1:0] w_load_val;

    always_comb begin
        w_on_time  = ({{(c_OT_W-c_BRIGHT_W){1'b0}}, brightness} + c_OT_W'(1)) << plane;
        w_load_val = w_on_time + c_OT_W'(c_DEAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_on_cnt <= '0;
        end else if (load) begin
            r_on_cnt <= w_load_val;
        end else if (r_on_cnt != '0) begin
            r_on_cnt <= r_on_cnt - c_OT_W'(1);
        end
    end

    // Counter is zero after the coming edge, so the FSM can latch with no bubble.
    assign done = (r_on_cnt <= c_OT_W'(1));

`ifdef HUB75_DEADTIME_EN
    logic [1:0] r_dead;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dead <= 2'd0;
        end else if (load) begin
            r_dead <= 2'd2;
        end else if (r_dead != 2'd0) begin
            r_dead <= r_dead - 2'd1;
        end
    end

    assign blank_req = (r_on_cnt == '0) || (r_dead != 2'd0);
`else
    assign blank_req = (r_on_cnt == '0);
`endif

endmodule
`default_nettype wire

// File: rtl/hub75_bcm_sched.sv
`default_nettype none
// ============================================================================
// Module      : hub75_bcm_sched
// Description : HUB75 binary-code-modulation scan scheduler; shifting of the
//               next plane overlaps display of the current one.
//               Optional macro: HUB75_DEADTIME_EN (2 blank cycles after latch).
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_bcm_sched
    import hub75_pkg::*;
#(
    parameter  int COL_BITS = c_DEF_COL_BITS,
    parameter  int ROW_BITS = c_DEF_ROW_BITS,
    parameter  int PLANES   = c_DEF_PLANES,
    localparam int PB       = plane_bits(PLANES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [c_BRIGHT_W-1:0] brightness,
    output logic [COL_BITS-1:0]   addrx,
    output logic [ROW_BITS-1:0]   shift_row,
    output logic [PB-1:0]         shift_plane,
    output logic                  sclk_en,
    output logic [ROW_BITS-1:0]   addry,
    output logic                  latch,
    output logic                  blank,
    output logic                  frame_start
);

    localparam logic [COL_BITS-1:0] c_LAST_COL   = '1;
    localparam logic [PB-1:0]       c_LAST_PLANE = PB'(PLANES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [COL_BITS-1:0] r_addrx;
    logic [ROW_BITS-1:0] r_row;
    logic [PB-1:0]       r_plane;
    logic [ROW_BITS-1:0] r_addry;
    logic                w_load;
    logic                w_blank_req;
    logic                w_done;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_next = S_SHIFT;
            S_SHIFT: if (r_addrx == c_LAST_COL) w_state_next = w_done ? S_LATCH : S_WAIT;
            S_WAIT:  if (w_done) w_state_next = S_LATCH;
            S_LATCH: w_state_next = enable ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift position advances at the latch; IDLE keeps it so a restart resumes there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addrx <= '0;
            r_row   <= '0;
            r_plane <= '0;
            r_addry <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_SHIFT) begin
                r_addrx <= r_addrx + COL_BITS'(1);
            end
            if (r_state == S_LATCH) begin
                r_addry <= r_row;
                if (r_plane == c_LAST_PLANE) begin
                    r_plane <= '0;
                    r_row   <= r_row + ROW_BITS'(1);
                end else begin
                    r_plane <= r_plane + PB'(1);
                end
            end
        end
    end

    assign w_load = (r_state == S_LATCH);

    hub75_on_timer #(
        .PLANES (PLANES),
        .PB     (PB)
    ) u_on_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .plane      (r_plane),
        .brightness (brightness),
        .blank_req  (w_blank_req),
        .done       (w_done)
    );

    assign addrx       = r_addrx;
    assign shift_row   = r_row;
    assign shift_plane = r_plane;
    assign addry       = r_addry;
    assign sclk_en     = (r_state == S_SHIFT);
    assign latch       = w_load;
    assign blank       = reset | w_load | w_blank_req;
    assign frame_start = w_load && (r_row == '0) && (r_plane == '0);

endmodule
`default_nettype wire
